// File: rtl/debouncer_pkg.sv
// Shared board-timing constants and width helpers for the debouncer.
package debouncer_pkg;

  // At 12.5 MHz this gives a 5 ms sample tick.
  localparam int unsigned BoardSampleCntMax = 62500;
  // 200 stable samples of 5 ms each declare a press (about 1 s).
  localparam int unsigned BoardPulseCntMax  = 200;

  // Bits needed to hold the values 0..n-1. Never returns less than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debouncer_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs. The async reset clears both stages.
module debouncer_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Metastability chain: only the second stage goes downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/debouncer.sv
// Per-bit push-button debouncer. Each bit passes through a 2-flop synchronizer.
// A saturating counter then counts consecutive high samples taken on a shared
// slow tick. A low sample clears the counter at once, so a release is seen
// quickly. Release bounce only re-arms the counter.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = BoardSampleCntMax,
  parameter int unsigned PULSE_CNT_MAX  = BoardPulseCntMax
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal
);

  localparam int unsigned SampleW = cnt_width(SAMPLE_CNT_MAX);
  localparam int unsigned PulseW  = cnt_width(PULSE_CNT_MAX + 1);

  localparam logic [SampleW-1:0] SampleLast = SampleW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PulseW-1:0]  PulseSat   = PulseW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]             sync;
  logic [SampleW-1:0]           sample_cnt_q;
  logic [SampleW-1:0]           sample_cnt_d;
  logic                         sample_tick;
  logic [WIDTH-1:0][PulseW-1:0] cnt_q;
  logic [WIDTH-1:0][PulseW-1:0] cnt_d;

  debouncer_synchronizer #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (glitchy_signal),
    .q     (sync)
  );

  // Shared sample-tick divider: counts 0..SAMPLE_CNT_MAX-1 and wraps.
  always_comb begin
    sample_tick  = (sample_cnt_q == SampleLast);
    sample_cnt_d = sample_tick ? '0 : sample_cnt_q + SampleW'(1);
  end

  // Divider state; reset restarts the tick phase from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Per-bit stable-high counter: a low sync clears it (this wins over a tick).
  // Otherwise it increments on a tick and saturates at PULSE_CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!sync[i]) begin
        cnt_d[i] = '0;
      end else if (sample_tick && (cnt_q[i] != PulseSat)) begin
        cnt_d[i] = cnt_q[i] + PulseW'(1);
      end
    end
  end

  // Pulse counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output decoded purely from registered counts; no path from the raw inputs.
  always_comb begin
    debounced_signal = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      debounced_signal[i] = (cnt_q[i] == PulseSat);
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
// "Cycle n" is the clock period that ends at posedge n. Cycle 0 ends at the
// first posedge after reset release. Inputs driven in cycle n are seen by
// posedge n. Outputs checked in cycle n are the values that posedge n sees.
module tb_debouncer;

  localparam int unsigned Width        = 2;
  localparam int unsigned SampleCntMax = 4;
  localparam int unsigned PulseCntMax  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [Width-1:0] glitchy_signal;
  logic [Width-1:0] debounced_signal;

  int n_checks = 0;
  int n_errors = 0;
  int cur      = 0;

  always #5 clk = ~clk;

  debouncer #(
    .WIDTH          (Width),
    .SAMPLE_CNT_MAX (SampleCntMax),
    .PULSE_CNT_MAX  (PulseCntMax)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .glitchy_signal   (glitchy_signal),
    .debounced_signal (debounced_signal)
  );

  task automatic check_eq(input string tag, input logic [Width-1:0] got,
                          input logic [Width-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cur);
    end
  endtask

  // Move into the next cycle, 1 time unit past the posedge.
  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic advance_to(input int n);
    while (cur < n) step();
  endtask

  task automatic expect_at(input string tag, input int n, input logic [Width-1:0] exp);
    advance_to(n);
    check_eq($sformatf("%s_c%0d", tag, n), debounced_signal, exp);
  endtask

  // Reset, then release mid-cycle so that the next posedge is cycle 0.
  task automatic start(input logic [Width-1:0] g);
    rst_n          = 1'b0;
    glitchy_signal = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("in_reset", debounced_signal, 2'b00);
    @(negedge clk);
    rst_n          = 1'b1;
    glitchy_signal = g;
    cur            = 0;
    #1;
    check_eq("after_reset", debounced_signal, 2'b00);
  endtask

  // Release bounce on bit 0: no high run lasts long enough for 3 ticks.
  logic [15:0] bounce = 16'b0110_1110_0100_1101;

  initial begin
    // 1. Clean press: ticks at 3, 7, 11, so the output rises in cycle 12.
    start(2'b01);
    expect_at("press", 11, 2'b00);
    expect_at("press", 12, 2'b01);
    expect_at("press", 16, 2'b01);

    // 3. Release at cycle 16: the output is low exactly 3 cycles later. Bounce adds no edge.
    glitchy_signal = 2'b00;
    expect_at("release", 18, 2'b01);
    expect_at("release", 19, 2'b00);
    for (int i = 0; i < 16; i++) begin
      glitchy_signal = {1'b0, bounce[i]};
      step();
      check_eq($sformatf("bounce_%0d", i), debounced_signal, 2'b00);
    end
    glitchy_signal = 2'b00;

    // 2a. Glitch low in cycle 8: sync is low in cycle 10, so the count clears.
    // Sync is high again by the tick in cycle 11, which therefore counts. Ticks 11,15,19 -> rise at 20.
    start(2'b01);
    advance_to(8);
    glitchy_signal = 2'b00;
    advance_to(9);
    glitchy_signal = 2'b01;
    expect_at("glitch8", 12, 2'b00);
    expect_at("glitch8", 19, 2'b00);
    expect_at("glitch8", 20, 2'b01);

    // 2b. Glitch low in cycle 9: sync is low during the cycle-11 tick and the clear wins.
    // Ticks 15, 19, 23 -> rise at 24.
    start(2'b01);
    advance_to(9);
    glitchy_signal = 2'b00;
    advance_to(10);
    glitchy_signal = 2'b01;
    expect_at("glitch9", 20, 2'b00);
    expect_at("glitch9", 23, 2'b00);
    expect_at("glitch9", 24, 2'b01);

    // 4. Saturation: the counter must not wrap, so the output never dips.
    for (int i = 0; i < 50; i++) begin
      step();
      check_eq($sformatf("sat_%0d", i), debounced_signal, 2'b01);
    end

    // 5. Independence: bit 1 starts at cycle 4 and rises at 16. Dropping bit 1 leaves bit 0 alone.
    start(2'b01);
    advance_to(4);
    glitchy_signal = 2'b11;
    expect_at("indep", 11, 2'b00);
    expect_at("indep", 12, 2'b01);
    expect_at("indep", 15, 2'b01);
    expect_at("indep", 16, 2'b11);
    advance_to(20);
    glitchy_signal = 2'b01;
    expect_at("drop1", 22, 2'b11);
    expect_at("drop1", 23, 2'b01);
    expect_at("drop1", 30, 2'b01);

    // 6. Async reset mid-cycle: the output falls before any clock edge.
    // After release the press sequence repeats exactly.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", debounced_signal, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    cur   = 0;
    #1;
    check_eq("rst_release", debounced_signal, 2'b00);
    expect_at("repeat", 11, 2'b00);
    expect_at("repeat", 12, 2'b01);
    expect_at("repeat", 14, 2'b01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
